// File: rtl/and_sweep_pkg.sv
// ----------------------------------------------------------------------------
// and_sweep_pkg
// Shared definitions for the AND-tree sweep controller:
//   - sweepState_t : FSM state encoding (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3)
//   - DEFAULT_VEC_W / DEFAULT_HOLD_CYCLES : default parameter values
//   - HOLD_COUNT_W : width of the hold counter (covers HOLD_CYCLES up to 255)
// No ports; imported by and_sweep_ctrl and sweep_hold_timer.
// ----------------------------------------------------------------------------
package and_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweepState_t;

    localparam int DEFAULT_VEC_W       = 4;
    localparam int DEFAULT_HOLD_CYCLES = 4;
    localparam int HOLD_COUNT_W        = 8;

endpackage : and_sweep_pkg

// File: rtl/sweep_hold_timer.sv
// ----------------------------------------------------------------------------
// sweep_hold_timer
// Counts the cycles a test vector has been held on the AND-tree inputs.
// The count starts at 0 on the first enabled cycle after a clear, and
// expire is high during the enabled cycle in which the count equals
// HOLD_CYCLES-1, i.e. the last cycle of the hold window.
//
// Parameters
//   HOLD_CYCLES : hold window length in cycles, legal range 1..255
// Ports
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-high reset (count -> 0)
//   clear  in  1  synchronous clear, has priority over enable
//   enable in  1  advance the count this cycle
//   expire out 1  last cycle of the hold window
// ----------------------------------------------------------------------------
module sweep_hold_timer
    import and_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [HOLD_COUNT_W-1:0] LAST_COUNT = HOLD_COUNT_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_COUNT_W-1:0] COUNT_INC  = HOLD_COUNT_W'(1);

    logic [HOLD_COUNT_W-1:0] holdCount;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdCount <= '0;
        end else if (clear) begin
            holdCount <= '0;
        end else if (enable) begin
            holdCount <= holdCount + COUNT_INC;
        end
    end

    assign expire = enable && (holdCount == LAST_COUNT);

endmodule : sweep_hold_timer

// File: rtl/and_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// and_sweep_ctrl
// Exhaustively sweeps all 2**VEC_W input vectors into a downstream AND tree.
// Each vector is held for HOLD_CYCLES cycles (DRIVE), then the tree output
// is checked against the AND-reduction of the vector for one cycle (SAMPLE).
// Mismatches are counted (saturating) and the first failing vector is kept.
// One vector costs HOLD_CYCLES+1 cycles; a full sweep 2**VEC_W*(HOLD_CYCLES+1).
//
// Parameters
//   HOLD_CYCLES : cycles each vector is held before sampling (1..255)
//   VEC_W       : number of tree inputs driven
// Ports
//   clk            in  1        rising-edge clock
//   rst            in  1        asynchronous active-high reset
//   startIn        in  1        start pulse, honoured in IDLE or DONE
//   abortIn        in  1        terminates a sweep in DRIVE/SAMPLE
//   gIn            in  1        AND-tree result
//   vecOut         out VEC_W    tree inputs (MSB..LSB = aIn, bIn, cIn, dIn)
//   busyOut        out 1        high in DRIVE and SAMPLE
//   doneOut        out 1        high in DONE
//   errCount       out VEC_W+1  mismatching vectors in the last/current sweep
//   firstFailVec   out VEC_W    first mismatching vector
//   firstFailValid out 1        firstFailVec holds a valid vector
//   passMap        out 2**VEC_W per-vector pass flags (AND_SWEEP_PASSMAP_EN only)
//
// Build option
//   AND_SWEEP_PASSMAP_EN : when defined, adds the passMap output and register.
// ----------------------------------------------------------------------------
module and_sweep_ctrl
    import and_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int VEC_W       = DEFAULT_VEC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startIn,
    input  logic                 abortIn,
    input  logic                 gIn,
    output logic [VEC_W-1:0]     vecOut,
    output logic                 busyOut,
    output logic                 doneOut,
    output logic [VEC_W:0]       errCount,
    output logic [VEC_W-1:0]     firstFailVec,
`ifdef AND_SWEEP_PASSMAP_EN
    output logic                 firstFailValid,
    output logic [2**VEC_W-1:0]  passMap
`else
    output logic                 firstFailValid
`endif
);

    localparam logic [VEC_W-1:0] LAST_VEC = '1;
    localparam logic [VEC_W-1:0] VEC_INC  = VEC_W'(1);
    localparam logic [VEC_W:0]   ERR_MAX  = (VEC_W + 1)'(2**VEC_W);
    localparam logic [VEC_W:0]   ERR_INC  = (VEC_W + 1)'(1);

    sweepState_t state;
    sweepState_t nextState;
    logic        holdExpire;
    logic        mismatch;

    // ------------------------------------------------------------------------
    // Hold counter: free to count only in DRIVE, cleared in every other state
    // so each vector's hold window starts from zero.
    // ------------------------------------------------------------------------
    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != DRIVE),
        .enable (state == DRIVE),
        .expire (holdExpire)
    );

    // Only meaningful in SAMPLE: the tree must equal the AND of its inputs.
    assign mismatch = (gIn != (&vecOut));

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic. abortIn wins over startIn while busy; startIn
    // wins while idle or done (abortIn has no meaning there).
    // ------------------------------------------------------------------------
    // NOTE: nextState gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (startIn) nextState = DRIVE;
            end
            DRIVE: begin
                if (abortIn)         nextState = IDLE;
                else if (holdExpire) nextState = SAMPLE;
            end
            SAMPLE: begin
                if (abortIn)                nextState = IDLE;
                else if (vecOut == LAST_VEC) nextState = DONE;
                else                        nextState = DRIVE;
            end
            DONE: begin
                if (startIn) nextState = DRIVE;
            end
            default: nextState = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busyOut = 1'b0;
        doneOut = 1'b0;
        unique case (state)
            DRIVE, SAMPLE: busyOut = 1'b1;
            DONE:          doneOut = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sweep datapath: vector, error count and first-failure capture.
    // The SAMPLE result is folded in at the edge leaving SAMPLE, so the last
    // vector's mismatch is already counted when DONE is entered. An abort
    // discards the pending sample and keeps the results gathered so far.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vecOut         <= '0;
            errCount       <= '0;
            firstFailVec   <= '0;
            firstFailValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (startIn) begin
                        vecOut         <= '0;
                        errCount       <= '0;
                        firstFailVec   <= '0;
                        firstFailValid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abortIn) vecOut <= '0;
                end
                SAMPLE: begin
                    if (abortIn) begin
                        vecOut <= '0;
                    end else begin
                        if (mismatch) begin
                            if (errCount != ERR_MAX) errCount <= errCount + ERR_INC;
                            if (!firstFailValid) begin
                                firstFailVec   <= vecOut;
                                firstFailValid <= 1'b1;
                            end
                        end
                        // The last vector stays on the tree through DONE.
                        if (vecOut != LAST_VEC) vecOut <= vecOut + VEC_INC;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AND_SWEEP_PASSMAP_EN
    // ------------------------------------------------------------------------
    // Per-vector pass flags, cleared on start so they describe one sweep.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            passMap <= '0;
        end else if ((state == IDLE || state == DONE) && startIn) begin
            passMap <= '0;
        end else if (state == SAMPLE && !abortIn && !mismatch) begin
            passMap[vecOut] <= 1'b1;
        end
    end
`endif

endmodule : and_sweep_ctrl

// File: tb/tb_and_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_and_sweep_ctrl
// Directed self-checking bench for and_sweep_ctrl at default parameters
// (VEC_W=4, HOLD_CYCLES=4: 5 cycles per vector, 80 cycles per sweep).
// treeMode selects the downstream tree: 0 = correct AND, 1 = stuck at 0,
// 2 = stuck at 1. Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        startIn;
    logic        abortIn;
    logic        gIn;
    logic [3:0]  vecOut;
    logic        busyOut;
    logic        doneOut;
    logic [4:0]  errCount;
    logic [3:0]  firstFailVec;
    logic        firstFailValid;
`ifdef AND_SWEEP_PASSMAP_EN
    logic [15:0] passMap;
`endif

    int checks = 0;
    int errors = 0;
    int treeMode = 0;

    and_sweep_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .startIn        (startIn),
        .abortIn        (abortIn),
        .gIn            (gIn),
        .vecOut         (vecOut),
        .busyOut        (busyOut),
        .doneOut        (doneOut),
        .errCount       (errCount),
        .firstFailVec   (firstFailVec),
`ifdef AND_SWEEP_PASSMAP_EN
        .firstFailValid (firstFailValid),
        .passMap        (passMap)
`else
        .firstFailValid (firstFailValid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream tree model.
    always @* begin
        case (treeMode)
            1:       gIn = 1'b0;
            2:       gIn = 1'b1;
            default: gIn = vecOut[3] & vecOut[2] & vecOut[1] & vecOut[0];
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start pulse seen by exactly one rising edge; returns at the falling
    // edge right after the start edge (sweep cycle 0).
    task automatic pulse_start();
        @(negedge clk);
        startIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
    endtask

    // Follows a sweep from cycle 0 until doneOut, checking vecOut and busyOut
    // every cycle. startIn is pulsed at cycles glitchA/glitchB (-1 = none).
    task automatic track_sweep(input int glitchA, input int glitchB, output int cycles);
        int k;
        logic [3:0] expVec;
        k = 0;
        while (k < 200 && doneOut !== 1'b1) begin
            expVec = (k / 5 > 15) ? 4'd15 : 4'(k / 5);
            checks++;
            if (vecOut !== expVec) begin
                errors++;
                $display("FAIL sweep_vec cycle=%0d vecOut=%0d expected=%0d", k, vecOut, expVec);
            end
            checks++;
            if (busyOut !== 1'b1) begin
                errors++;
                $display("FAIL sweep_busy cycle=%0d busyOut=%b expected=1", k, busyOut);
            end
            startIn = (k == glitchA || k == glitchB);
            @(negedge clk);
            k++;
        end
        startIn = 1'b0;
        cycles = k;
    endtask

    task automatic wait_vec(input logic [3:0] v, output bit found);
        int k;
        found = 1'b0;
        for (k = 0; k < 200; k++) begin
            if (vecOut === v) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        startIn = 1'b0;
        abortIn = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({vecOut, busyOut, doneOut, errCount, firstFailVec, firstFailValid} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs vec=%0d busy=%b done=%b err=%0d ffVec=%0d ffValid=%b expected all 0",
                     vecOut, busyOut, doneOut, errCount, firstFailVec, firstFailValid);
        end
`ifdef AND_SWEEP_PASSMAP_EN
        checks++;
        if (passMap !== 16'h0000) begin
            errors++;
            $display("FAIL reset_passmap passMap=%h expected=0000", passMap);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busyOut !== 1'b0 || doneOut !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b expected 0 0", busyOut, doneOut);
        end
    endtask

    task automatic test_clean_sweep();
        int cycles;
        treeMode = 0;
        pulse_start();
        track_sweep(-1, -1, cycles);
        checks++;
        if (cycles !== 80) begin
            errors++;
            $display("FAIL clean_length cycles=%0d expected=80", cycles);
        end
        checks++;
        if (errCount !== 5'd0 || firstFailValid !== 1'b0) begin
            errors++;
            $display("FAIL clean_result err=%0d ffValid=%b expected 0 0", errCount, firstFailValid);
        end
        checks++;
        if (vecOut !== 4'd15 || busyOut !== 1'b0) begin
            errors++;
            $display("FAIL clean_done_vec vecOut=%0d busy=%b expected 15 0", vecOut, busyOut);
        end
`ifdef AND_SWEEP_PASSMAP_EN
        checks++;
        if (passMap !== 16'hFFFF) begin
            errors++;
            $display("FAIL clean_passmap passMap=%h expected=ffff", passMap);
        end
`endif
    endtask

    task automatic test_done_hold();
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (doneOut !== 1'b1 || vecOut !== 4'd15 || errCount !== 5'd0) begin
            errors++;
            $display("FAIL done_hold done=%b vecOut=%0d err=%0d expected 1 15 0", doneOut, vecOut, errCount);
        end
    endtask

    task automatic test_stuck_low();
        int cycles;
        treeMode = 1;
        pulse_start();
        track_sweep(-1, -1, cycles);
        checks++;
        if (cycles !== 80) begin
            errors++;
            $display("FAIL low_length cycles=%0d expected=80", cycles);
        end
        checks++;
        if (errCount !== 5'd1 || firstFailVec !== 4'd15 || firstFailValid !== 1'b1) begin
            errors++;
            $display("FAIL low_result err=%0d ffVec=%0d ffValid=%b expected 1 15 1",
                     errCount, firstFailVec, firstFailValid);
        end
`ifdef AND_SWEEP_PASSMAP_EN
        checks++;
        if (passMap !== 16'h7FFF) begin
            errors++;
            $display("FAIL low_passmap passMap=%h expected=7fff", passMap);
        end
`endif
    endtask

    task automatic test_stuck_high();
        int cycles;
        treeMode = 2;
        pulse_start();
        track_sweep(-1, -1, cycles);
        checks++;
        if (cycles !== 80) begin
            errors++;
            $display("FAIL high_length cycles=%0d expected=80", cycles);
        end
        checks++;
        if (errCount !== 5'd15 || firstFailVec !== 4'd0 || firstFailValid !== 1'b1) begin
            errors++;
            $display("FAIL high_result err=%0d ffVec=%0d ffValid=%b expected 15 0 1",
                     errCount, firstFailVec, firstFailValid);
        end
`ifdef AND_SWEEP_PASSMAP_EN
        checks++;
        if (passMap !== 16'h8000) begin
            errors++;
            $display("FAIL high_passmap passMap=%h expected=8000", passMap);
        end
`endif
    endtask

    task automatic test_abort();
        bit found;
        int cycles;
        treeMode = 2;
        pulse_start();
        wait_vec(4'd6, found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_vec6 vecOut=%0d expected=6", vecOut);
        end
        // Abort and start together while busy: abort wins.
        startIn = 1'b1;
        abortIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        abortIn = 1'b0;
        checks++;
        if (vecOut !== 4'd0 || busyOut !== 1'b0 || doneOut !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle vecOut=%0d busy=%b done=%b expected 0 0 0", vecOut, busyOut, doneOut);
        end
        checks++;
        if (errCount !== 5'd6 || firstFailVec !== 4'd0 || firstFailValid !== 1'b1) begin
            errors++;
            $display("FAIL abort_retain err=%0d ffVec=%0d ffValid=%b expected 6 0 1",
                     errCount, firstFailVec, firstFailValid);
        end
        @(negedge clk);
        checks++;
        if (busyOut !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle busy=%b expected=0", busyOut);
        end
        // Abort and start together while idle: start wins.
        treeMode = 0;
        startIn = 1'b1;
        abortIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        abortIn = 1'b0;
        track_sweep(-1, -1, cycles);
        checks++;
        if (cycles !== 80) begin
            errors++;
            $display("FAIL restart_length cycles=%0d expected=80", cycles);
        end
        checks++;
        if (errCount !== 5'd0 || firstFailValid !== 1'b0) begin
            errors++;
            $display("FAIL restart_result err=%0d ffValid=%b expected 0 0", errCount, firstFailValid);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        treeMode = 2;
        pulse_start();
        wait_vec(4'd9, found);
        @(negedge clk);
        checks++;
        if (!found || errCount !== 5'd9 || busyOut !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset found=%b err=%0d busy=%b expected 1 9 1", found, errCount, busyOut);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vecOut, busyOut, doneOut, errCount, firstFailVec, firstFailValid} !== 15'd0) begin
            errors++;
            $display("FAIL midreset_outputs vec=%0d busy=%b done=%b err=%0d ffVec=%0d ffValid=%b expected all 0",
                     vecOut, busyOut, doneOut, errCount, firstFailVec, firstFailValid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busyOut !== 1'b0 || vecOut !== 4'd0) begin
            errors++;
            $display("FAIL midreset_idle busy=%b vecOut=%0d expected 0 0", busyOut, vecOut);
        end
    endtask

    task automatic test_start_ignored();
        int cycles;
        treeMode = 0;
        pulse_start();
        // Cycle 20 is DRIVE of vector 4, cycle 44 is SAMPLE of vector 8.
        track_sweep(20, 44, cycles);
        checks++;
        if (cycles !== 80) begin
            errors++;
            $display("FAIL start_ignored_length cycles=%0d expected=80", cycles);
        end
        checks++;
        if (errCount !== 5'd0 || firstFailValid !== 1'b0 || vecOut !== 4'd15) begin
            errors++;
            $display("FAIL start_ignored_result err=%0d ffValid=%b vecOut=%0d expected 0 0 15",
                     errCount, firstFailValid, vecOut);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_done_hold();
        test_stuck_low();
        test_stuck_high();
        test_abort();
        test_reset_mid_sweep();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_and_sweep_ctrl
